// File: rtl/truth_table_sweep_ctrl_pkg.sv
// Shared types and helpers for the LED truth-table sweep controller.
package truth_table_pkg;

  // Controller operating modes; also exported for display blocks.
  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SWEEP  = 2'd1,
    PAUSE  = 2'd2
  } state_e;

  // Debounced switch pattern that requests sweep mode from manual mode.
  localparam logic [3:0] ENTRY_CHORD = 4'b1111;

  // LED word {LED4,LED3,LED2,LED1} for an input vector {d,c,b,a}.
  function automatic logic [3:0] led_word(input logic [3:0] vec);
    logic a, b, c, d;
    a = vec[0];
    b = vec[1];
    c = vec[2];
    d = vec[3];
    led_word[0] = a & b;
    led_word[1] = (a & c) | d;
    led_word[2] = ~(b & d) & c;
    led_word[3] = a & b & c & d;
  endfunction

endpackage

// File: rtl/truth_table_sweep_ctrl_if.sv
// Board-side signal bundle: raw switches in, LEDs and status out.
interface truth_table_sweep_ctrl_if;
  import truth_table_pkg::*;

  logic       i_Switch_1;
  logic       i_Switch_2;
  logic       i_Switch_3;
  logic       i_Switch_4;
  logic       o_LED_1;
  logic       o_LED_2;
  logic       o_LED_3;
  logic       o_LED_4;
  logic [3:0] o_Vector;
  logic       o_Sweep_Active;
  logic       o_Paused;

  // Board / stimulus side: drives switches, observes LEDs and status.
  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    input  o_LED_1, o_LED_2, o_LED_3, o_LED_4,
    input  o_Vector, o_Sweep_Active, o_Paused
  );

  // Controller side.
  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    output o_LED_1, o_LED_2, o_LED_3, o_LED_4,
    output o_Vector, o_Sweep_Active, o_Paused
  );

endinterface

// File: rtl/truth_table_sweep_ctrl_debounce.sv
// Single-switch debouncer: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each debounced 0->1 transition.
module debounce_filter
  import truth_table_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise
);

  localparam int            CW       = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic          meta_r;
  logic          sync_r;
  logic          deb_r;
  logic          rise_r;
  logic [CW-1:0] cnt_r;

  // Bring the asynchronous switch level into the clock domain.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= i_Switch;
      sync_r <= meta_r;
    end
  end

  // Flip the debounced level once the synchronised level has disagreed for
  // DEBOUNCE_TICKS consecutive cycles; any agreement restarts the count.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_r  <= CNT_ZERO;
      deb_r  <= 1'b0;
      rise_r <= 1'b0;
    end else if (sync_r == deb_r) begin
      cnt_r  <= CNT_ZERO;
      rise_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= CNT_ZERO;
      deb_r  <= sync_r;
      rise_r <= sync_r;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
      rise_r <= 1'b0;
    end
  end

  assign o_Switch = deb_r;
  assign o_Rise   = rise_r;

endmodule

// File: rtl/truth_table_sweep_ctrl.sv
// Truth-table sequencer: manual mode mirrors the debounced switches, sweep
// mode steps the vector through all 16 combinations on a timer, with the
// switches reused as exit / pause / single-step controls.
module truth_table_sweep_ctrl
  import truth_table_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 250000,
  parameter int SWEEP_TICKS    = 12500000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  truth_table_sweep_ctrl_if.slave bus
);

  localparam logic [1:0]    ST_MANUAL  = MANUAL;
  localparam logic [1:0]    ST_SWEEP   = SWEEP;
  localparam logic [1:0]    ST_PAUSE   = PAUSE;
  localparam int            TW         = $clog2(SWEEP_TICKS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SWEEP_TICKS - 1);
  localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};

  logic [3:0]    sw_raw_s;
  logic [3:0]    deb_s;
  logic [3:0]    rise_s;
  logic [3:0]    deb_prev_r;
  logic          armed_r;
  logic          chord_s;
  logic          tc_s;
  logic [1:0]    state_r;
  logic [1:0]    state_n;
  logic [3:0]    vec_r;
  logic [3:0]    vec_n;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_n;
  logic [3:0]    led_r;
  logic          sweep_r;
  logic          paused_r;

  assign sw_raw_s = {bus.i_Switch_4, bus.i_Switch_3, bus.i_Switch_2, bus.i_Switch_1};

  for (genvar g = 0; g < 4; g++) begin : g_deb
    debounce_filter #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .i_Switch (sw_raw_s[g]),
      .o_Switch (deb_s[g]),
      .o_Rise   (rise_s[g])
    );
  end

  // The chord only arms after the debounced vector has moved to some
  // non-chord value, so switches held at 1111 through reset cannot enter
  // sweep mode until they are released and pressed again.
  assign chord_s = armed_r && (deb_s == ENTRY_CHORD) && (deb_prev_r != ENTRY_CHORD);
  assign tc_s    = (timer_r == TIMER_LAST);

  // Track the previous debounced vector and the chord arming flag.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      deb_prev_r <= 4'b0000;
      armed_r    <= 1'b0;
    end else begin
      deb_prev_r <= deb_s;
      armed_r    <= armed_r | ((deb_s != deb_prev_r) && (deb_s != ENTRY_CHORD));
    end
  end

  // Next-state, vector and timer decisions; exit beats pause/resume beats
  // the timer step or single-step within a cycle.
  always_comb begin
    state_n = state_r;
    vec_n   = vec_r;
    timer_n = timer_r;
    case (state_r)
      ST_MANUAL: begin
        timer_n = TIMER_ZERO;
        if (chord_s) begin
          state_n = ST_SWEEP;
          vec_n   = 4'd0;
        end else begin
          state_n = ST_MANUAL;
          vec_n   = deb_s;
        end
      end
      ST_SWEEP: begin
        if (rise_s[0]) begin
          state_n = ST_MANUAL;
          vec_n   = deb_s;
          timer_n = TIMER_ZERO;
        end else if (rise_s[1]) begin
          state_n = ST_PAUSE;
          timer_n = TIMER_ZERO;
        end else if (tc_s) begin
          timer_n = TIMER_ZERO;
          vec_n   = vec_r + 4'd1;
        end else begin
          timer_n = timer_r + TW'(1);
        end
      end
      ST_PAUSE: begin
        timer_n = TIMER_ZERO;
        if (rise_s[0]) begin
          state_n = ST_MANUAL;
          vec_n   = deb_s;
        end else if (rise_s[1]) begin
          state_n = ST_SWEEP;
        end else if (rise_s[2]) begin
          vec_n   = vec_r + 4'd1;
        end else begin
          state_n = ST_PAUSE;
        end
      end
      default: begin
        state_n = ST_MANUAL;
        vec_n   = 4'd0;
        timer_n = TIMER_ZERO;
      end
    endcase
  end

  // State, vector and sweep timer registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r <= ST_MANUAL;
      vec_r   <= 4'd0;
      timer_r <= TIMER_ZERO;
    end else begin
      state_r <= state_n;
      vec_r   <= vec_n;
      timer_r <= timer_n;
    end
  end

  // Registered LED word and mode status, one cycle behind vector/state.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      led_r    <= 4'b0000;
      sweep_r  <= 1'b0;
      paused_r <= 1'b0;
    end else begin
      led_r    <= led_word(vec_r);
      sweep_r  <= (state_r == ST_SWEEP) || (state_r == ST_PAUSE);
      paused_r <= (state_r == ST_PAUSE);
    end
  end

  assign bus.o_LED_1        = led_r[0];
  assign bus.o_LED_2        = led_r[1];
  assign bus.o_LED_3        = led_r[2];
  assign bus.o_LED_4        = led_r[3];
  assign bus.o_Vector       = vec_r;
  assign bus.o_Sweep_Active = sweep_r;
  assign bus.o_Paused       = paused_r;

endmodule
